// File: rtl/core_pkg.sv
// Shared decode-stage definitions for the pending-write scoreboard.
// Provides the register address type, the hard-wired zero register address
// and the architectural register count.
package core_pkg;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int NUM_REGS       = 2**REG_ADDR_WIDTH;

   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

   localparam reg_addr_t X0_ADDR = '0;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/write-back bundle between the decode stage (master) and the
// pending-write scoreboard (slave).
//   issue_*  : instruction presented for issue, with its sources and destination
//   wb_*     : write-back strobe and address (same as register_file write port)
interface reg_scoreboard_if #(
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      issue_valid_i;
   logic                      issue_ready_o;
   logic [REG_ADDR_WIDTH-1:0] rs1_addr_i;
   logic [REG_ADDR_WIDTH-1:0] rs2_addr_i;
   logic                      rs1_used_i;
   logic                      rs2_used_i;
   logic [REG_ADDR_WIDTH-1:0] rd_addr_i;
   logic                      rd_we_i;
   logic                      wb_valid_i;
   logic [REG_ADDR_WIDTH-1:0] wb_addr_i;

   modport master (
      output issue_valid_i, rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
             rd_addr_i, rd_we_i, wb_valid_i, wb_addr_i,
      input  issue_ready_o
   );

   modport slave (
      input  issue_valid_i, rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
             rd_addr_i, rd_we_i, wb_valid_i, wb_addr_i,
      output issue_ready_o
   );
endinterface

// File: rtl/reg_scoreboard_pending_counter.sv
// Per-register outstanding-write counter.
//   clk, rst     : clock, synchronous active-high reset
//   inc, dec     : one issue / one write-back this cycle (both => no change)
//   clr          : flush, forces zero and overrides inc/dec
//   is_zero      : current count is zero
//   is_max       : current count is at its saturation value
//   nonzero_next : next-state count is nonzero (feeds the registered busy flag)
module pending_counter #(
   parameter int CNT_WIDTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   input  logic clr,
   output logic is_zero,
   output logic is_max,
   output logic nonzero_next
);
   logic [CNT_WIDTH-1:0] cnt_reg;
   logic [CNT_WIDTH-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (clr) begin
         cnt_next = '0;
      end else if (inc && !dec) begin
         cnt_next = cnt_reg + CNT_WIDTH'(1);
      end else if (dec && !inc) begin
         cnt_next = cnt_reg - CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign is_zero      = (cnt_reg == '0);
   assign is_max       = (cnt_reg == '1);
   assign nonzero_next = (cnt_next != '0);
endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the decode stage. Tracks outstanding
// write-backs per architectural register (x0 excluded) and holds decode on
// read-after-write hazards and on counter saturation.
//   clk, rst        : clock, synchronous active-high reset
//   sb (slave)      : issue handshake, source/destination fields, write-back
//   flush_i         : kill all in-flight instructions, clear pending counts
//   stall_o         : instruction presented but not accepted
//   busy_o          : some register has a pending write (registered)
//   err_o           : sticky, write-back arrived with nothing pending
//   stall_cycles_o  : saturating stall-cycle counter
module reg_scoreboard #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 2,
   parameter int PERF_WIDTH     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   reg_scoreboard_if.slave       sb,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic                  busy_o,
   output logic                  err_o,
   output logic [PERF_WIDTH-1:0] stall_cycles_o
);
   import core_pkg::*;

   localparam int NREGS = 2**REG_ADDR_WIDTH;
   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(X0_ADDR);

   logic [NREGS-1:0]      zero_vec;
   logic [NREGS-1:0]      max_vec;
   logic [NREGS-1:0]      live_next;
   logic [NREGS-1:0]      inc_vec;
   logic [NREGS-1:0]      dec_vec;
   logic                  raw1;
   logic                  raw2;
   logic                  sat;
   logic                  ready;
   logic                  fire;
   logic                  wb_err;
   logic                  busy_reg;
   logic                  err_reg;
   logic [PERF_WIDTH-1:0] stall_cnt_reg;

   // x0 behaves as a counter that is always zero and never saturates.
   assign zero_vec[0]  = 1'b1;
   assign max_vec[0]   = 1'b0;
   assign live_next[0] = 1'b0;
   assign inc_vec[0]   = 1'b0;
   assign dec_vec[0]   = 1'b0;

   // The hazard view uses registered counts only: a write-back this cycle
   // does not release a reader until the next cycle.
   assign raw1  = sb.rs1_used_i && (sb.rs1_addr_i != ZERO_ADDR) && !zero_vec[sb.rs1_addr_i];
   assign raw2  = sb.rs2_used_i && (sb.rs2_addr_i != ZERO_ADDR) && !zero_vec[sb.rs2_addr_i];
   assign sat   = sb.rd_we_i && (sb.rd_addr_i != ZERO_ADDR) && max_vec[sb.rd_addr_i];
   assign ready = !(raw1 || raw2 || sat) && !flush_i;

   assign sb.issue_ready_o = ready;
   assign fire             = sb.issue_valid_i && ready;
   assign stall_o          = sb.issue_valid_i && !ready;

   genvar gi;
   generate
      for (gi = 1; gi < NREGS; gi++) begin : g_cnt
         assign inc_vec[gi] = fire && sb.rd_we_i &&
                              (sb.rd_addr_i == REG_ADDR_WIDTH'(gi));
         // An unexpected write-back must not underflow the counter.
         assign dec_vec[gi] = sb.wb_valid_i &&
                              (sb.wb_addr_i == REG_ADDR_WIDTH'(gi)) && !zero_vec[gi];

         pending_counter #(
            .CNT_WIDTH (CNT_WIDTH)
         ) u_cnt (
            .clk          (clk),
            .rst          (rst),
            .inc          (inc_vec[gi]),
            .dec          (dec_vec[gi]),
            .clr          (flush_i),
            .is_zero      (zero_vec[gi]),
            .is_max       (max_vec[gi]),
            .nonzero_next (live_next[gi])
         );
      end
   endgenerate

   // Write-backs of killed instructions during a flush are not errors.
   assign wb_err = sb.wb_valid_i && (sb.wb_addr_i != ZERO_ADDR) &&
                   zero_vec[sb.wb_addr_i] && !flush_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_reg      <= 1'b0;
         err_reg       <= 1'b0;
         stall_cnt_reg <= '0;
      end else begin
         busy_reg <= |live_next;
         if (wb_err) begin
            err_reg <= 1'b1;
         end
         if (stall_o && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + PERF_WIDTH'(1);
         end
      end
   end

   assign busy_o         = busy_reg;
   assign err_o          = err_reg;
   assign stall_cycles_o = stall_cnt_reg;
endmodule
